// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation at a time to a registered ALU and returns its result.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   op_valid/op_ready           request handshake (op_ready decoded from registered state)
//   op_code/op_a/op_b/op_shamt  operation and operands; op_tag returned with the result
//   alu_opcode/alu_in1/alu_in2/alu_shamt  drive to the ALU (opcode is NOP outside ISSUE)
//   alu_result                  ALU output, captured ALU_LATENCY cycles after issue
//   res_valid/res_ready         result handshake; res_data/res_tag/res_err payload
//   ops_done                    successful results delivered (wraps)
//   err_count                   error results delivered (saturates at 255)
module alu_issue_ctrl #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [4:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_shamt,
  input  logic [3:0]  op_tag,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_tag,
  output logic        res_err,
  output logic [15:0] ops_done,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        live_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  alu_opcode_q, alu_opcode_d;
  logic [31:0] alu_in1_q, alu_in1_d;
  logic [31:0] alu_in2_q, alu_in2_d;
  logic [4:0]  alu_shamt_q, alu_shamt_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic [3:0]  res_tag_q, res_tag_d;
  logic        res_err_q, res_err_d;
  logic [15:0] ops_done_q, ops_done_d;
  logic [7:0]  err_count_q, err_count_d;

  logic accept;
  logic op_bad;

  // live_q keeps op_ready low during reset and for the edge that follows release.
  assign op_ready = live_q && (state_q == StIdle);
  assign accept   = op_valid && op_ready;
  assign op_bad   = (op_code == 5'h00) || (op_code > 5'h0A) ||
                    (((op_code == 5'h04) || (op_code == 5'h05)) && (op_b == 32'h0));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_shamt_d  = alu_shamt_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    res_err_d    = res_err_q;
    ops_done_d   = ops_done_q;
    err_count_d  = err_count_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          res_tag_d = op_tag;
          if (op_bad) begin
            res_err_d  = 1'b1;
            res_data_d = 32'h0;
            state_d    = StDone;
          end else begin
            alu_opcode_d = op_code;
            alu_in1_d    = op_a;
            alu_in2_d    = op_b;
            alu_shamt_d  = op_shamt;
            state_d      = StIssue;
          end
        end
      end
      StIssue: begin
        alu_opcode_d = 5'h00;
        cnt_d        = 3'(ALU_LATENCY);
        state_d      = StWait;
      end
      StWait: begin
        if (cnt_q <= 3'd1) begin
          res_data_d  = alu_result;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDone: begin
        if (!res_valid_q) begin
          // Error path enters DONE straight from the accept; raise valid one edge later.
          res_valid_d = 1'b1;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
          if (res_err_q) begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          end else begin
            ops_done_d = ops_done_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      live_q       <= 1'b0;
      cnt_q        <= 3'd0;
      alu_opcode_q <= 5'h00;
      alu_in1_q    <= 32'h0;
      alu_in2_q    <= 32'h0;
      alu_shamt_q  <= 5'h00;
      res_valid_q  <= 1'b0;
      res_data_q   <= 32'h0;
      res_tag_q    <= 4'h0;
      res_err_q    <= 1'b0;
      ops_done_q   <= 16'h0;
      err_count_q  <= 8'h0;
    end else begin
      state_q      <= state_d;
      live_q       <= 1'b1;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_shamt_q  <= alu_shamt_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      res_err_q    <= res_err_d;
      ops_done_q   <= ops_done_d;
      err_count_q  <= err_count_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_shamt  = alu_shamt_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign res_err    = res_err_q;
  assign ops_done   = ops_done_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU latency 1 and 3), each fed by a bench ALU model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid [2];
  logic        op_ready [2];
  logic [4:0]  op_code [2];
  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic [4:0]  op_shamt [2];
  logic [3:0]  op_tag [2];
  logic [4:0]  alu_opcode [2];
  logic [31:0] alu_in1 [2];
  logic [31:0] alu_in2 [2];
  logic [4:0]  alu_shamt [2];
  logic [31:0] alu_result [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [31:0] res_data [2];
  logic [3:0]  res_tag [2];
  logic        res_err [2];
  logic [15:0] ops_done [2];
  logic [7:0]  err_count [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          exp_done [2];
  int          exp_err [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl #(.ALU_LATENCY(1)) u_dut0 (
    .clk(clk), .rst(rst), .op_valid(op_valid[0]), .op_ready(op_ready[0]),
    .op_code(op_code[0]), .op_a(op_a[0]), .op_b(op_b[0]), .op_shamt(op_shamt[0]),
    .op_tag(op_tag[0]), .alu_opcode(alu_opcode[0]), .alu_in1(alu_in1[0]),
    .alu_in2(alu_in2[0]), .alu_shamt(alu_shamt[0]), .alu_result(alu_result[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
    .res_tag(res_tag[0]), .res_err(res_err[0]), .ops_done(ops_done[0]),
    .err_count(err_count[0])
  );

  alu_issue_ctrl #(.ALU_LATENCY(3)) u_dut1 (
    .clk(clk), .rst(rst), .op_valid(op_valid[1]), .op_ready(op_ready[1]),
    .op_code(op_code[1]), .op_a(op_a[1]), .op_b(op_b[1]), .op_shamt(op_shamt[1]),
    .op_tag(op_tag[1]), .alu_opcode(alu_opcode[1]), .alu_in1(alu_in1[1]),
    .alu_in2(alu_in2[1]), .alu_shamt(alu_shamt[1]), .alu_result(alu_result[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
    .res_tag(res_tag[1]), .res_err(res_err[1]), .ops_done(ops_done[1]),
    .err_count(err_count[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (op)
      5'h01:   return a + b;
      5'h02:   return a - b;
      5'h03:   return a * b;
      5'h04:   return (b == 0) ? 32'h0 : a / b;
      5'h05:   return (b == 0) ? 32'h0 : a % b;
      5'h06:   return a & b;
      5'h07:   return a | b;
      5'h08:   return a ^ b;
      5'h09:   return a << sh;
      5'h0A:   return a >> sh;
      default: return 32'h0;
    endcase
  endfunction

  // Bench ALU: samples a non-NOP opcode at an edge, result visible lat(d)-1 edges later,
  // held while NOPs flow through.
  logic        pv [2][8];
  logic [31:0] pval [2][8];
  logic [31:0] hold [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pv[d][0]   <= (alu_opcode[d] != 5'h00);
      pval[d][0] <= alu_fn(alu_opcode[d], alu_in1[d], alu_in2[d], alu_shamt[d]);
      for (int s = 1; s < 8; s++) begin
        pv[d][s]   <= pv[d][s-1];
        pval[d][s] <= pval[d][s-1];
      end
      if (pv[d][lat(d)-1]) hold[d] <= pval[d][lat(d)-1];
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      alu_result[d] = pv[d][lat(d)-1] ? pval[d][lat(d)-1] : hold[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input int d, input string pfx);
    check($sformatf("%s d%0d op_ready", pfx, d), 32'(op_ready[d]), 0);
    check($sformatf("%s d%0d res_valid", pfx, d), 32'(res_valid[d]), 0);
    check($sformatf("%s d%0d res_data", pfx, d), res_data[d], 0);
    check($sformatf("%s d%0d res_tag", pfx, d), 32'(res_tag[d]), 0);
    check($sformatf("%s d%0d res_err", pfx, d), 32'(res_err[d]), 0);
    check($sformatf("%s d%0d alu_opcode", pfx, d), 32'(alu_opcode[d]), 0);
    check($sformatf("%s d%0d alu_in1", pfx, d), alu_in1[d], 0);
    check($sformatf("%s d%0d alu_in2", pfx, d), alu_in2[d], 0);
    check($sformatf("%s d%0d alu_shamt", pfx, d), 32'(alu_shamt[d]), 0);
    check($sformatf("%s d%0d ops_done", pfx, d), 32'(ops_done[d]), 0);
    check($sformatf("%s d%0d err_count", pfx, d), 32'(err_count[d]), 0);
  endtask

  task automatic wait_ready(input int d);
    int guard = 0;
    while (!op_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("d%0d op_ready before accept", d), 32'(op_ready[d]), 1);
  endtask

  // One op with res_ready held high; called just after a negedge.
  task automatic do_op(input int d, input logic [4:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [3:0] tag);
    logic        bad;
    logic [31:0] exp_data;
    logic [4:0]  issued_op;
    int          k, issued, lat_exp;
    bad       = (code == 5'h00) || (code > 5'h0A) ||
                (((code == 5'h04) || (code == 5'h05)) && (b == 0));
    exp_data  = bad ? 32'h0 : alu_fn(code, a, b, sh);
    lat_exp   = bad ? 1 : lat(d) + 1;
    issued    = 0;
    issued_op = 5'h00;
    op_code[d] = code; op_a[d] = a; op_b[d] = b; op_shamt[d] = sh; op_tag[d] = tag;
    op_valid[d] = 1'b1;
    res_ready[d] = 1'b1;
    wait_ready(d);
    @(posedge clk);
    @(negedge clk);
    op_valid[d] = 1'b0;
    k = 0;
    while (!res_valid[d] && k < 20) begin
      if (alu_opcode[d] != 5'h00) begin
        issued++;
        issued_op = alu_opcode[d];
      end
      @(negedge clk);
      k++;
    end
    check($sformatf("d%0d op%0h latency", d, code), k, lat_exp);
    check($sformatf("d%0d op%0h issue cycles", d, code), issued, bad ? 0 : 1);
    check($sformatf("d%0d op%0h issued opcode", d, code), 32'(issued_op), bad ? 0 : 32'(code));
    check($sformatf("d%0d op%0h res_data", d, code), res_data[d], exp_data);
    check($sformatf("d%0d op%0h res_tag", d, code), 32'(res_tag[d]), 32'(tag));
    check($sformatf("d%0d op%0h res_err", d, code), 32'(res_err[d]), 32'(bad));
    @(negedge clk);
    if (bad) begin
      if (exp_err[d] < 255) exp_err[d]++;
    end else begin
      exp_done[d] = (exp_done[d] + 1) % 65536;
    end
    check($sformatf("d%0d op%0h res_valid one cycle", d, code), 32'(res_valid[d]), 0);
    check($sformatf("d%0d op%0h op_ready after", d, code), 32'(op_ready[d]), 1);
    check($sformatf("d%0d ops_done", d), 32'(ops_done[d]), exp_done[d]);
    check($sformatf("d%0d err_count", d), 32'(err_count[d]), exp_err[d]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  rc;
    logic [31:0] rb;
    int          stamps [3];
    int          nres, guard, seen;

    for (int d = 0; d < 2; d++) begin
      op_valid[d] = 1'b0; op_code[d] = 5'h00; op_a[d] = 0; op_b[d] = 0;
      op_shamt[d] = 5'h00; op_tag[d] = 4'h0; res_ready[d] = 1'b1;
      exp_done[d] = 0; exp_err[d] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero(0, "reset");
    check_zero(1, "reset");
    rst = 1'b0;
    @(negedge clk);
    check("d0 op_ready after release", 32'(op_ready[0]), 1);

    // Add, latency 1
    do_op(0, 5'h01, 32'd7, 32'd5, 5'd0, 4'd3);
    // Divide / modulo by zero
    do_op(0, 5'h04, 32'd100, 32'd0, 5'd0, 4'd9);
    do_op(0, 5'h05, 32'd100, 32'd0, 5'd0, 4'd1);
    // Illegal opcodes
    do_op(0, 5'h00, 32'd1, 32'd2, 5'd0, 4'd4);
    do_op(0, 5'h0B, 32'd1, 32'd2, 5'd0, 4'd5);
    do_op(0, 5'h1F, 32'd1, 32'd2, 5'd0, 4'd6);

    // Backpressure: sub 10-3 with res_ready low for 5 cycles and a second op pending
    op_code[0] = 5'h02; op_a[0] = 32'd10; op_b[0] = 32'd3; op_tag[0] = 4'd2;
    op_valid[0] = 1'b1;
    res_ready[0] = 1'b0;
    wait_ready(0);
    @(posedge clk);
    @(negedge clk);
    op_code[0] = 5'h01; op_a[0] = 32'd1; op_b[0] = 32'd1; op_tag[0] = 4'd7;
    guard = 0;
    while (!res_valid[0] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp res_valid held", 32'(res_valid[0]), 1);
      check("bp res_data stable", res_data[0], 32'd7);
      check("bp res_tag stable", 32'(res_tag[0]), 32'd2);
      check("bp op_ready low", 32'(op_ready[0]), 0);
      check("bp no reissue", 32'(alu_opcode[0]), 0);
      @(negedge clk);
    end
    op_valid[0] = 1'b0;
    res_ready[0] = 1'b1;
    @(negedge clk);
    exp_done[0]++;
    check("bp op_ready after handshake", 32'(op_ready[0]), 1);
    check("bp res_valid after handshake", 32'(res_valid[0]), 0);
    check("bp ops_done", 32'(ops_done[0]), exp_done[0]);

    // Latency 3, mul 6*7
    do_op(1, 5'h03, 32'd6, 32'd7, 5'd0, 4'd8);
    do_op(1, 5'h05, 32'd6, 32'd0, 5'd0, 4'd2);

    // Randomized ops on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        rc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 10));
        rb = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        do_op(d, rc, $urandom, rb, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
      end
    end

    // Back-to-back throughput on the latency-3 instance
    op_code[1] = 5'h03; op_a[1] = 32'd6; op_b[1] = 32'd7; op_tag[1] = 4'd1;
    res_ready[1] = 1'b1;
    op_valid[1] = 1'b1;
    nres = 0;
    guard = 0;
    while (nres < 3 && guard < 60) begin
      @(negedge clk);
      guard++;
      if (res_valid[1]) begin
        check("b2b res_data", res_data[1], 32'd42);
        stamps[nres] = cyc;
        nres++;
        if (nres == 3) op_valid[1] = 1'b0;
      end
    end
    check("b2b results seen", nres, 3);
    check("b2b period 1", stamps[1] - stamps[0], 6);
    check("b2b period 2", stamps[2] - stamps[1], 6);
    @(negedge clk);
    exp_done[1] += 3;
    check("b2b ops_done", 32'(ops_done[1]), exp_done[1]);

    // Illegal-op flood to saturate err_count
    for (int i = 0; i < 260; i++) begin
      do_op(0, 5'h0B + 5'(i % 21), 32'(i), 32'd1, 5'd0, 4'(i));
    end
    check("err_count saturated", 32'(err_count[0]), 255);

    // Reset during WAIT on the latency-3 instance
    op_code[1] = 5'h03; op_a[1] = 32'd6; op_b[1] = 32'd7; op_tag[1] = 4'd5;
    op_valid[1] = 1'b1;
    wait_ready(1);
    @(posedge clk);
    @(negedge clk);
    op_valid[1] = 1'b0;
    @(negedge clk);
    check("pre-reset alu_in1 loaded", alu_in1[1], 32'd6);
    rst = 1'b1;
    #1;
    check_zero(1, "midreset");
    check_zero(0, "midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("op_ready one cycle after release", 32'(op_ready[1]), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid[1]) seen++;
      @(negedge clk);
    end
    check("no result after reset", seen, 0);
    check("ops_done after reset", 32'(ops_done[1]), 0);
    check("err_count after reset", 32'(err_count[0]), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencer that issues one operation at a time to the registered ALU and returns its result to the requester. Accepts an operation over a valid/ready handshake, screens illegal opcodes and divide-by-zero, drives the ALU's opcode/operand inputs for exactly one cycle, waits out the ALU latency, captures the result, and presents it downstream over a second valid/ready handshake. Sits between the instruction decode stage and the ALU. It is the initiator side of the ALU operation interface.

## Interface
- ALU_LATENCY, 1: cycles from the ALU sampling its opcode to its result being valid (1..7).
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- op_valid  input  1  request valid.
- op_ready  output  1  request accepted when op_valid & op_ready at the rising edge.
- op_code  input  5  ALU opcode; legal 5'h01..5'h0A.
- op_a, op_b  input  32  operands (unsigned).
- op_shamt  input  5  shift/rotate amount, forwarded.
- op_tag  input  4  requester tag, returned unchanged.
- alu_opcode  output  5  to ALU; 5'h00 (NOP, ALU holds result) when not issuing.
- alu_in1, alu_in2  output  32  to ALU input_1/input_2.
- alu_shamt  output  5  to ALU s_r_amount.
- alu_result  input  32  from ALU.
- res_valid  output  1  result valid.
- res_ready  input  1  downstream accepts.
- res_data  output  32  result.
- res_tag  output  4  tag of the op.
- res_err  output  1  1 = illegal opcode or divide/modulo by zero.
- ops_done  output  16  count of successful results delivered, wraps.
- err_count  output  8  count of error results delivered, saturates at 255.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. op_ready = (state == IDLE), decoded from the registered state.
- IDLE: on accept, latch op_code/op_a/op_b/op_shamt/op_tag.
  - If op_code is outside 5'h01..5'h0A, or op_code ∈ {5'h04, 5'h05} with op_b == 0: go to DONE with res_err = 1, res_data = 0. Nothing is issued to the ALU.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): alu_opcode/alu_in1/alu_in2/alu_shamt carry the latched values. Next state is WAIT. Load the wait counter with ALU_LATENCY.
- WAIT: alu_opcode = NOP. The operand outputs hold their values. Decrement the counter each cycle. On the edge where the counter reaches 1, capture alu_result into res_data, set res_err = 0, and go to DONE.
- DONE: res_valid = 1. res_data/res_tag/res_err stay stable until the handshake. On res_valid & res_ready: go to IDLE, increment ops_done (if !res_err) or err_count (if res_err, saturating).
- Only one operation is in flight. op_valid is ignored outside IDLE.
- Reset (any time, including mid-operation): state becomes IDLE and the in-flight op is dropped with no result.
  - Reset values are 0 for op_ready, res_valid, res_data, res_tag, res_err, alu_opcode, alu_in1, alu_in2, alu_shamt, ops_done and err_count.
  - op_ready rises in the first cycle after rst deasserts.

## Timing
- All outputs are registered except op_ready, which is a decode of the registered state.
- Legal op accepted at edge E0: alu_opcode is valid between E0 and E1. The ALU samples it at E1. res_valid is high after edge E(ALU_LATENCY+1).
- Error op accepted at E0: res_valid is high after E1.
- With res_ready held high, res_valid is high for 1 cycle, and op_ready returns the cycle after the result handshake.
- Throughput (legal ops): one op per ALU_LATENCY+3 cycles.
- No combinational path from op_valid to op_ready, or from res_ready to res_valid.

## Test plan
- Add, ALU_LATENCY=1: op_code=5'h01, a=7, b=5, tag=3, res_ready=1.
  - alu_opcode=5'h01 for exactly one cycle, then 5'h00.
  - res_valid 2 cycles after accept, res_data=12, res_tag=3, res_err=0, ops_done=1.
- Divide by zero: op_code=5'h04, b=0.
  - alu_opcode never leaves 5'h00.
  - res_valid 1 cycle after accept, res_err=1, res_data=0, err_count=1.
- Illegal opcodes: op_code=5'h00, 5'h0B and 5'h1F, each accepted.
  - Each returns res_err=1.
  - Drive 260 illegal ops and check that err_count saturates at 255.
- Backpressure: sub 10-3, res_ready low for 5 cycles.
  - res_valid stays high and res_data=7 stays stable.
  - op_ready stays 0 and a second op_valid is not accepted.
  - After res_ready goes high, op_ready=1 on the next cycle.
- Latency parameter: ALU_LATENCY=3 with a mul 6*7 bench ALU model.
  - res_data=42, with res_valid 4 cycles after accept.
  - Back-to-back ops reach the 6-cycle throughput.
- Reset mid-op: assert rst during WAIT.
  - All outputs go to 0 immediately.
  - No res_valid appears after release, op_ready=1 one cycle after release, and ops_done=0.
